// File: rtl/imem_boot_seq.sv
// Boot loader and fetch sequencer for the core's instruction memory: streams a program
// in over a valid/ready port, then releases the core and drives the PC.
module imem_boot_seq #(
    parameter int                 ADDR_W    = 5,
    parameter int                 DATA_W    = 32,
    parameter int                 DEPTH     = 32,
    parameter logic [DATA_W-1:0]  HALT_WORD = 32'hFFFF_FFFF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start_load,
    input  logic                start_run,
    input  logic                ld_valid,
    input  logic [DATA_W-1:0]   ld_data,
    input  logic                ld_last,
    output logic                ld_ready,
    output logic                mem_we,
    output logic [ADDR_W-1:0]   mem_waddr,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [ADDR_W-1:0]   imem_addr,
    input  logic [DATA_W-1:0]   imem_rdata,
    input  logic                br_valid,
    input  logic [ADDR_W-1:0]   br_target,
    output logic                cpu_run,
    output logic [ADDR_W:0]     load_count,
    output logic                trunc_flag,
    output logic [2:0]          state_o
);

    localparam int CW = ADDR_W + 1;
    localparam logic [CW-1:0]     FULL_CNT  = CW'(DEPTH);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_FLUSH = 3'd2,
        S_RUN   = 3'd3,
        S_HALT  = 3'd4
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   pc_q, pc_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic                trunc_q, trunc_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   waddr_q, waddr_d;
    logic [DATA_W-1:0]   wdata_q, wdata_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            trunc_q <= 1'b0;
            we_q    <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            trunc_q <= trunc_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        trunc_d = trunc_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        case (state_q)
            S_IDLE, S_HALT: begin
                if (start_load) begin
                    state_d = S_LOAD;
                    cnt_d   = '0;
                    trunc_d = 1'b0;
                end else if (start_run) begin
                    state_d = S_RUN;
                    pc_d    = '0;
                end
            end
            S_LOAD: begin
                if (ld_valid) begin
                    we_d    = 1'b1;
                    waddr_d = cnt_q[ADDR_W-1:0];
                    wdata_d = ld_data;
                    if (cnt_q != FULL_CNT) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                    // A full memory without ld_last ends the load and is flagged as truncated.
                    if (ld_last) begin
                        state_d = S_FLUSH;
                    end else if (cnt_q[ADDR_W-1:0] == LAST_ADDR) begin
                        state_d = S_FLUSH;
                        trunc_d = 1'b1;
                    end
                end
            end
            S_FLUSH: begin
                state_d = S_RUN;
                pc_d    = '0;
            end
            S_RUN: begin
                if (imem_rdata == HALT_WORD) begin
                    state_d = S_HALT;
                end else if (br_valid) begin
                    pc_d = br_target;
                end else if (pc_q == LAST_ADDR) begin
                    pc_d = '0;
                end else begin
                    pc_d = pc_q + 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign ld_ready   = (state_q == S_LOAD);
    assign cpu_run    = (state_q == S_RUN);
    assign mem_we     = we_q;
    assign mem_waddr  = waddr_q;
    assign mem_wdata  = wdata_q;
    assign imem_addr  = pc_q;
    assign load_count = cnt_q;
    assign trunc_flag = trunc_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_imem_boot_seq.sv
// Directed-plus-random bench for imem_boot_seq with a word-level model of loading and PC flow.
module tb_imem_boot_seq;

    localparam int          AW    = 5;
    localparam int          DW    = 32;
    localparam int          DEPTH = 32;
    localparam logic [31:0] HALT  = 32'hFFFF_FFFF;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_load = 1'b0;
    logic          start_run = 1'b0;
    logic          ld_valid = 1'b0;
    logic [DW-1:0] ld_data = '0;
    logic          ld_last = 1'b0;
    logic          ld_ready;
    logic          mem_we;
    logic [AW-1:0] mem_waddr;
    logic [DW-1:0] mem_wdata;
    logic [AW-1:0] imem_addr;
    logic [DW-1:0] imem_rdata;
    logic          br_valid = 1'b0;
    logic [AW-1:0] br_target = '0;
    logic          cpu_run;
    logic [AW:0]   load_count;
    logic          trunc_flag;
    logic [2:0]    state_o;

    int checks = 0;
    int failures = 0;
    int m_pc = 0;
    logic [31:0] prog      [DEPTH];
    logic [31:0] model_mem [DEPTH];
    logic [31:0] env_mem   [DEPTH];

    imem_boot_seq #(.ADDR_W(AW), .DATA_W(DW), .DEPTH(DEPTH), .HALT_WORD(HALT)) dut (
        .clk(clk), .reset(reset), .start_load(start_load), .start_run(start_run),
        .ld_valid(ld_valid), .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
        .imem_addr(imem_addr), .imem_rdata(imem_rdata),
        .br_valid(br_valid), .br_target(br_target), .cpu_run(cpu_run),
        .load_count(load_count), .trunc_flag(trunc_flag), .state_o(state_o)
    );

    always #5 clk = ~clk;

    // Instruction memory the DUT writes into and the core fetches from.
    always @(posedge clk) if (mem_we) env_mem[mem_waddr] <= mem_wdata;
    assign imem_rdata = env_mem[imem_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] rnd_word();
        return $urandom & 32'h7FFF_FFFF;
    endfunction

    task automatic do_load(input int n, input bit mark_last, input bit toggle);
        int sent = 0;
        int cyc = 0;
        bit done = 1'b0;
        bit hs;
        while (!done && cyc < 4 * DEPTH) begin
            ld_valid   = toggle ? (cyc % 2 == 0) : 1'b1;
            ld_data    = prog[sent];
            ld_last    = mark_last && (sent == n - 1);
            start_run  = ($urandom_range(0, 3) == 0);
            start_load = ($urandom_range(0, 3) == 0);
            chk("ld_ready_in_load", ld_ready, 1);
            hs = ld_valid;
            step();
            chk("mem_we", mem_we, hs);
            if (hs) begin
                chk("mem_waddr", mem_waddr, sent);
                chk("mem_wdata", mem_wdata, prog[sent]);
                model_mem[sent] = prog[sent];
                done = ld_last || (sent + 1 == DEPTH);
                sent++;
            end
            chk("load_count", load_count, sent);
            if (!done) chk("load_state", state_o, 1);
            cyc++;
        end
        ld_valid = 1'b0; ld_last = 1'b0; start_run = 1'b0; start_load = 1'b0;
        if (!done) begin
            checks++;
            failures++;
            $error("FAIL load_timeout observed=%0d words expected=%0d", sent, n);
        end
        chk("flush_state", state_o, 2);
        chk("flush_ld_ready", ld_ready, 0);
        chk("flush_cpu_run", cpu_run, 0);
        chk("trunc_flag", trunc_flag, (!mark_last && sent == DEPTH));
    endtask

    task automatic flush_to_run(input bit extra_valid, input int exp_cnt);
        ld_valid = extra_valid;
        ld_data  = 32'h1234_5678;
        step();
        ld_valid = 1'b0;
        chk("run_entry_state", state_o, 3);
        chk("run_entry_we", mem_we, 0);
        chk("run_entry_cnt", load_count, exp_cnt);
        m_pc = 0;
    endtask

    task automatic run_prog(input int max_cyc, input int dir_pc, input int dir_tgt,
                            input bit rand_br, input bit br_on_halt, input bit expect_halt);
        bit halted = 1'b0;
        int cyc = 0;
        logic [31:0] word;
        while (!halted && cyc < max_cyc) begin
            chk("run_state", state_o, 3);
            chk("run_cpu_run", cpu_run, 1);
            chk("run_pc", imem_addr, m_pc);
            word = model_mem[m_pc];
            br_valid   = (m_pc == dir_pc) || (rand_br && $urandom_range(0, 3) == 0)
                         || (br_on_halt && word == HALT);
            br_target  = (m_pc == dir_pc) ? 5'(dir_tgt) : 5'($urandom_range(0, DEPTH - 1));
            start_load = rand_br && ($urandom_range(0, 7) == 0);
            start_run  = rand_br && ($urandom_range(0, 7) == 0);
            step();
            if (word == HALT) halted = 1'b1;
            else if (br_valid) m_pc = int'(br_target);
            else m_pc = (m_pc + 1) % DEPTH;
            cyc++;
        end
        br_valid = 1'b0; start_load = 1'b0; start_run = 1'b0;
        if (expect_halt) begin
            chk("halt_reached", halted, 1);
            chk("halt_state", state_o, 4);
            chk("halt_cpu_run", cpu_run, 0);
            chk("halt_pc", imem_addr, m_pc);
        end else begin
            chk("still_run", state_o, 3);
            chk("still_run_pc", imem_addr, m_pc);
        end
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) model_mem[i] = 32'h0;

        // Reset and idle behaviour
        reset = 1'b1;
        step(); step();
        chk("rst_state", state_o, 0);
        chk("rst_ld_ready", ld_ready, 0);
        chk("rst_we", mem_we, 0);
        chk("rst_waddr", mem_waddr, 0);
        chk("rst_wdata", mem_wdata, 0);
        chk("rst_pc", imem_addr, 0);
        chk("rst_cpu_run", cpu_run, 0);
        chk("rst_cnt", load_count, 0);
        chk("rst_trunc", trunc_flag, 0);
        reset = 1'b0;
        repeat (3) step();
        chk("idle_state", state_o, 0);
        chk("idle_ld_ready", ld_ready, 0);

        // Three-word program ending in HALT
        prog[0] = 32'hA000_0001; prog[1] = 32'hA000_0002; prog[2] = HALT;
        start_load = 1'b1; step(); start_load = 1'b0;
        chk("load_enter", state_o, 1);
        chk("load_cnt_clr", load_count, 0);
        do_load(3, 1'b1, 1'b0);
        flush_to_run(1'b0, 3);
        run_prog(10, -1, 0, 1'b0, 1'b0, 1'b1);

        // Both starts from HALT: load wins; backpressured load; branch ignored on halt
        start_load = 1'b1; start_run = 1'b1; step(); start_load = 1'b0; start_run = 1'b0;
        chk("load_wins", state_o, 1);
        prog[0] = rnd_word(); prog[1] = rnd_word(); prog[2] = HALT; prog[3] = rnd_word();
        do_load(4, 1'b1, 1'b1);
        flush_to_run(1'b0, 4);
        run_prog(10, -1, 0, 1'b0, 1'b1, 1'b1);

        // Rerun existing contents from HALT
        start_run = 1'b1; step(); start_run = 1'b0;
        chk("rerun_state", state_o, 3);
        m_pc = 0;
        run_prog(10, -1, 0, 1'b0, 1'b0, 1'b1);

        // Full-depth load without ld_last, then a rejected 33rd word
        start_load = 1'b1; step(); start_load = 1'b0;
        chk("trunc_clr", trunc_flag, 0);
        for (int i = 0; i < DEPTH; i++) prog[i] = rnd_word();
        do_load(DEPTH, 1'b0, 1'b0);
        chk("full_cnt", load_count, DEPTH);
        flush_to_run(1'b1, DEPTH);
        chk("trunc_sticky", trunc_flag, 1);

        // Running halt-free contents: directed branch, wrap, then random branches and ignored starts
        run_prog(40, 2, 5, 1'b0, 1'b0, 1'b0);
        run_prog(60, -1, 0, 1'b1, 1'b0, 1'b0);

        // Reset mid-run, then reset mid-load after two words
        reset = 1'b1; step(); reset = 1'b0;
        chk("rst_run_state", state_o, 0);
        chk("rst_run_cpu", cpu_run, 0);
        chk("rst_run_pc", imem_addr, 0);
        start_load = 1'b1; step(); start_load = 1'b0;
        for (int k = 0; k < 2; k++) begin
            ld_valid = 1'b1; ld_data = rnd_word(); ld_last = 1'b0;
            step();
            chk("part_we", mem_we, 1);
            chk("part_waddr", mem_waddr, k);
            chk("part_wdata", mem_wdata, ld_data);
            model_mem[k] = ld_data;
        end
        chk("part_cnt", load_count, 2);
        reset = 1'b1; ld_valid = 1'b1; ld_data = rnd_word();
        step();
        reset = 1'b0; ld_valid = 1'b0;
        chk("rst_load_state", state_o, 0);
        chk("rst_load_cnt", load_count, 0);
        chk("rst_load_we", mem_we, 0);
        chk("rst_load_ready", ld_ready, 0);
        start_load = 1'b1; step(); start_load = 1'b0;
        prog[0] = rnd_word(); prog[1] = rnd_word(); prog[2] = rnd_word(); prog[3] = HALT;
        do_load(4, 1'b1, 1'b0);
        flush_to_run(1'b0, 4);
        run_prog(10, -1, 0, 1'b0, 1'b0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/imem_boot_seq.md
Name: imem_boot_seq

Overview:
- Boot loader and fetch sequencer for the 32x32 instruction memory of the single-cycle core.
- After reset it streams a program into the memory over a valid/ready port, then releases the core and drives the fetch address (PC), including branch redirect and halt detection.
- Sits between the host/debug loader, the instruction memory write/read ports and the core's enable.

Parameters:
- ADDR_W, 5, instruction memory address width
- DATA_W, 32, instruction width
- DEPTH, 32, number of memory words (2**ADDR_W)
- HALT_WORD, 32'hFFFF_FFFF, instruction encoding that stops execution

Ports:
- clk  in  1  clock, all state updates on rising edge
- reset  in  1  synchronous, active-high
- start_load  in  1  pulse: begin program load from address 0
- start_run  in  1  pulse: run existing memory contents from PC 0
- ld_valid  in  1  loader word valid
- ld_data  in  DATA_W  loader word
- ld_last  in  1  marks final program word
- ld_ready  out  1  controller accepts loader word
- mem_we  out  1  instruction memory write enable (registered)
- mem_waddr  out  ADDR_W  write address (registered)
- mem_wdata  out  DATA_W  write data (registered)
- imem_addr  out  ADDR_W  fetch address = PC
- imem_rdata  in  DATA_W  instruction read combinationally at imem_addr
- br_valid  in  1  core requests PC redirect this cycle
- br_target  in  ADDR_W  redirect address
- cpu_run  out  1  core execute enable
- load_count  out  ADDR_W+1  words written in current/last load
- trunc_flag  out  1  sticky: load ended at full depth without ld_last
- state_o  out  3  encoded state for debug: IDLE=0, LOAD=1, FLUSH=2, RUN=3, HALT=4

Behaviour:
- Reset, sync, active-high; clock clk. Any cycle with reset=1, including mid-load or mid-run, forces IDLE on the next edge.
- Reset values: all outputs 0; PC 0; load_count 0; trunc_flag 0.
- IDLE:
  - ld_ready=0, cpu_run=0.
  - start_load -> LOAD: clears load_count and trunc_flag.
  - Else start_run -> RUN with PC=0.
  - If both are asserted, load wins.
- LOAD:
  - ld_ready=1.
  - A handshake (ld_valid & ld_ready) registers mem_we=1, mem_waddr=load_count[ADDR_W-1:0], mem_wdata=ld_data on the next cycle, and increments load_count. mem_we is 0 in cycles with no handshake.
  - A handshake with ld_last=1 -> FLUSH.
  - A handshake at address DEPTH-1 with ld_last=0 -> FLUSH and trunc_flag set.
  - ld_ready drops to 0 in the cycle after the final handshake; no further words are accepted.
  - start_run/start_load are ignored while in LOAD.
- FLUSH:
  - One cycle; the final mem_we pulse is issued here.
  - ld_ready=0, cpu_run=0, then -> RUN with PC=0.
  - Guarantees the last word is written before the first fetch.
- RUN:
  - cpu_run=1, imem_addr=PC.
  - Each cycle, with priority halt > branch > increment:
    - imem_rdata==HALT_WORD -> HALT, PC held, cpu_run=0 from the next cycle.
    - Else br_valid=1 -> PC=br_target.
    - Else PC=PC+1, wrapping DEPTH-1 -> 0.
  - start pulses are ignored.
- HALT:
  - cpu_run=0; imem_addr holds the halting PC.
  - start_load -> LOAD; start_run -> RUN with PC=0; load wins if both.
- Latency:
  - Handshake to mem_we: 1 cycle.
  - Final handshake to first cpu_run=1: 2 cycles.
- load_count saturates at DEPTH (6'd32) and holds its value after load until the next start_load.

Test Plan:
- Reset -> all outputs 0, state_o=0; after 3 idle cycles with no start, still IDLE and ld_ready=0.
- start_load, then 3 words A0000001/A0000002/FFFFFFFF (last on third), back-to-back:
  - Required: mem_we pulses at addrs 0,1,2 with matching data; load_count=3.
  - Required: FLUSH for 1 cycle, then RUN with imem_addr 0,1,2; at addr 2 HALT_WORD is read, and cpu_run=0 the following cycle.
- Loader backpressure: ld_valid toggles 1,0,1,0 over 4 words -> exactly 4 mem_we pulses at addrs 0-3, none in gap cycles.
- 32 words with ld_last never asserted:
  - Required: writes to addrs 0..31, load_count=32, trunc_flag=1, ld_ready=0 after the 32nd handshake.
  - Required: a 33rd valid word is not accepted.
- RUN with non-halt contents:
  - br_valid=1, br_target=5 at PC=2 -> next PC=5.
  - PC=31 with no branch -> next PC=0.
  - br_valid while imem_rdata=HALT_WORD -> HALT, PC unchanged.
- reset=1 asserted mid-load after 2 words -> next cycle IDLE, load_count=0, mem_we=0; a new start_load restarts writing at addr 0.
